// File: rtl/ht_serial_pkg.sv
// Shared definitions for the HT serial bus (used by both master and slave).
package ht_serial_pkg;

  localparam int unsigned HT_FRAME_W  = 16;
  localparam int unsigned HT_ADDR_W   = 6;
  localparam int unsigned HT_DATA_W   = 9;
  localparam int unsigned HT_RW_BIT   = 0;
  localparam int unsigned HT_CMD_BITS = 7;
  localparam int unsigned HT_CNT_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_WDATA = 3'd2,
    ST_RDATA = 3'd3,
    ST_DONE  = 3'd4
  } ht_state_e;

  // Frame payload as it appears on the wire, bit 0 first.
  typedef struct packed {
    logic [HT_DATA_W-1:0] data;
    logic [HT_ADDR_W-1:0] addr;
    logic                 rw;
  } ht_frame_t;

endpackage

// File: rtl/ht_sync_edge.sv
// Multi-flop synchroniser for one asynchronous bus input, plus rise/fall detect.
module ht_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_LVL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchroniser chain followed by a single edge-detect flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_LVL}};
      prev_q <= RST_LVL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_c  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_c  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/ht_serial_slave.sv
// HT serial bus slave: 16-bit frame decoder, NUM_REGS x 9-bit register file,
// local access port and read-data tristate.
// Optional feature macro: HT_SLV_FRMCNT_EN (top address becomes a frame counter).
module ht_serial_slave
  import ht_serial_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_REGS    = 16,
  parameter logic [8:0]  RST_VAL     = 9'h000
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       SCLK_pin,
  input  logic       SLOAD_pin,
  inout  wire        SDATA_pin,
  input  logic [5:0] loc_addr,
  input  logic       loc_wr_en,
  input  logic [8:0] loc_wdata,
  output logic [8:0] loc_rdata,
  output logic       wr_strobe,
  output logic [5:0] wr_addr,
  output logic [8:0] wr_data,
  output logic       frame_err
);

  localparam int unsigned NUM_ADDR = 1 << HT_ADDR_W;
  localparam logic [HT_CNT_W-1:0] LAST_BIT = HT_CNT_W'(HT_FRAME_W - 1);
  localparam logic [HT_CNT_W-1:0] CMD_LAST = HT_CNT_W'(HT_CMD_BITS - 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic sload_lvl, sload_rise, sload_fall;
  logic sdata_lvl, sdata_rise, sdata_fall;

  ht_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_LVL(1'b0)) u_sync_sclk (
    .clk(clk_50m), .rst(rst), .d_i(SCLK_pin),
    .level_o(sclk_lvl), .rise_c(sclk_rise), .fall_c(sclk_fall)
  );

  ht_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_LVL(1'b1)) u_sync_sload (
    .clk(clk_50m), .rst(rst), .d_i(SLOAD_pin),
    .level_o(sload_lvl), .rise_c(sload_rise), .fall_c(sload_fall)
  );

  ht_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_LVL(1'b0)) u_sync_sdata (
    .clk(clk_50m), .rst(rst), .d_i(SDATA_pin),
    .level_o(sdata_lvl), .rise_c(sdata_rise), .fall_c(sdata_fall)
  );

  ht_state_e                state_q, state_d;
  logic [HT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [HT_FRAME_W-2:0]    frm_q, frm_d;
  logic [HT_DATA_W-1:0]     rsh_q, rsh_d;
  logic                     sdo_q, sdo_d;
  logic                     oe_q, oe_d;
  logic                     wr_strobe_q, wr_strobe_d;
  logic [HT_ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [HT_DATA_W-1:0]     wr_data_q, wr_data_d;
  logic                     frame_err_q, frame_err_d;
  logic                     commit_c, done_c;
  logic [HT_ADDR_W-1:0]     cmd_addr_c;
  ht_frame_t                frame_c;
  logic [HT_DATA_W-1:0]     regs_q [NUM_REGS];
  logic [HT_DATA_W-1:0]     view_c [NUM_ADDR];
  logic                     unused_ok;

  // Address being completed at the bit-6 rise, and the whole frame at the bit-15 rise.
  assign cmd_addr_c = {sdata_lvl, frm_q[HT_CMD_BITS-2:1]};
  assign frame_c    = ht_frame_t'({sdata_lvl, frm_q});

  assign unused_ok = ^{sclk_lvl, sload_rise, sload_fall, sdata_rise, sdata_fall, frame_c.rw};

  // FSM state register.
  always_ff @(posedge clk_50m) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic; a synchronised SLOAD high always ends the frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!sload_lvl) state_d = ST_CMD;
      ST_CMD: begin
        if (sload_lvl) state_d = ST_IDLE;
        else if (sclk_rise && bit_cnt_q == CMD_LAST)
          state_d = frm_q[HT_RW_BIT] ? ST_RDATA : ST_WDATA;
      end
      ST_WDATA, ST_RDATA: begin
        if (sload_lvl) state_d = ST_IDLE;
        else if (sclk_rise && bit_cnt_q == LAST_BIT) state_d = ST_DONE;
      end
      ST_DONE:  if (sload_lvl) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM output/datapath logic: bit capture, read shifter, commit and abort pulses.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    frm_d       = frm_q;
    rsh_d       = rsh_q;
    sdo_d       = sdo_q;
    oe_d        = oe_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    commit_c    = 1'b0;
    done_c      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        oe_d      = 1'b0;
      end
      ST_CMD, ST_WDATA, ST_RDATA: begin
        if (sload_lvl) begin
          frame_err_d = 1'b1;
          oe_d        = 1'b0;
          bit_cnt_d   = '0;
        end else begin
          if (sclk_rise) begin
            if (bit_cnt_q != LAST_BIT) begin
              frm_d[bit_cnt_q] = sdata_lvl;
              bit_cnt_d        = bit_cnt_q + HT_CNT_W'(1);
            end
            if (state_q == ST_CMD && bit_cnt_q == CMD_LAST)
              rsh_d = view_c[cmd_addr_c];
            if (state_q != ST_CMD && bit_cnt_q == LAST_BIT) begin
              done_c = 1'b1;
              if (state_q == ST_WDATA) begin
                commit_c    = 1'b1;
                wr_strobe_d = 1'b1;
                wr_addr_d   = frame_c.addr;
                wr_data_d   = frame_c.data;
              end
            end
          end
          if (sclk_fall && state_q == ST_RDATA) begin
            oe_d  = 1'b1;
            sdo_d = rsh_q[0];
            rsh_d = {1'b0, rsh_q[HT_DATA_W-1:1]};
          end
        end
      end
      ST_DONE: begin
        if (sclk_fall || sload_lvl) oe_d = 1'b0;
      end
      default: begin
        bit_cnt_d = '0;
        oe_d      = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      bit_cnt_q   <= '0;
      frm_q       <= '0;
      rsh_q       <= '0;
      sdo_q       <= 1'b0;
      oe_q        <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      frm_q       <= frm_d;
      rsh_q       <= rsh_d;
      sdo_q       <= sdo_d;
      oe_q        <= oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef HT_SLV_FRMCNT_EN
  localparam int unsigned NUM_RW = NUM_REGS - 1;
  logic [HT_DATA_W-1:0] frm_cnt_q;

  // Completed-frame counter, wraps naturally at 2^HT_DATA_W.
  always_ff @(posedge clk_50m) begin
    if (rst)         frm_cnt_q <= '0;
    else if (done_c) frm_cnt_q <= frm_cnt_q + HT_DATA_W'(1);
  end
`else
  localparam int unsigned NUM_RW = NUM_REGS;
`endif

  // Writable registers; a serial commit beats a local write in the same cycle.
  for (genvar g = 0; g < NUM_RW; g++) begin : g_reg
    always_ff @(posedge clk_50m) begin
      if (rst)
        regs_q[g] <= RST_VAL;
      else if (commit_c && frame_c.addr == HT_ADDR_W'(g))
        regs_q[g] <= frame_c.data;
      else if (loc_wr_en && loc_addr == HT_ADDR_W'(g))
        regs_q[g] <= loc_wdata;
    end
  end

  // Full 64-entry read view: unimplemented addresses read as zero.
  for (genvar g = 0; g < NUM_ADDR; g++) begin : g_view
    if (g >= NUM_REGS) begin : g_nil
      assign view_c[g] = '0;
`ifdef HT_SLV_FRMCNT_EN
    end else if (g == NUM_REGS - 1) begin : g_cnt
      assign view_c[g] = frm_cnt_q;
`endif
    end else begin : g_imp
      assign view_c[g] = regs_q[g];
    end
  end

  assign loc_rdata = view_c[loc_addr];
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_err = frame_err_q;

  // Release the bus immediately on reset or once SLOAD is seen high.
  assign SDATA_pin = (oe_q && !rst && !sload_lvl) ? sdo_q : 1'bz;

endmodule

// File: tb/tb_ht_serial_slave.sv
// Self-checking bench for ht_serial_slave: bit-banged bus master plus register model.
module tb_ht_serial_slave;

  localparam int NREGS = 16;

  logic       clk_50m = 1'b0;
  logic       rst = 1'b0;
  logic       SCLK_pin = 1'b0;
  logic       SLOAD_pin = 1'b1;
  logic       m_oe = 1'b0;
  logic       m_do = 1'b0;
  wire        SDATA_pin;
  logic [5:0] loc_addr = '0;
  logic       loc_wr_en = 1'b0;
  logic [8:0] loc_wdata = '0;
  logic [8:0] loc_rdata;
  logic       wr_strobe;
  logic [5:0] wr_addr;
  logic [8:0] wr_data;
  logic       frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;

  logic       coll_arm = 1'b0;
  logic [5:0] coll_addr = '0;
  logic [8:0] coll_data = '0;

  logic [8:0] mregs [NREGS];
  int         mcnt = 0;

  always #10 clk_50m = ~clk_50m;

  assign SDATA_pin = m_oe ? m_do : 1'bz;
  pullup (SDATA_pin);

  ht_serial_slave #(.SYNC_STAGES(2), .NUM_REGS(NREGS), .RST_VAL(9'h000)) dut (
    .clk_50m(clk_50m), .rst(rst), .SCLK_pin(SCLK_pin), .SLOAD_pin(SLOAD_pin),
    .SDATA_pin(SDATA_pin), .loc_addr(loc_addr), .loc_wr_en(loc_wr_en),
    .loc_wdata(loc_wdata), .loc_rdata(loc_rdata), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .wr_data(wr_data), .frame_err(frame_err)
  );

  always @(negedge clk_50m) begin
    if (wr_strobe) strobe_cnt++;
    if (frame_err) err_cnt++;
  end

  function automatic logic [8:0] mread(input int a);
    if (a >= NREGS) return 9'h000;
`ifdef HT_SLV_FRMCNT_EN
    if (a == NREGS - 1) return 9'(mcnt);
`endif
    return mregs[a];
  endfunction

  function automatic void mwrite(input int a, input logic [8:0] d);
    if (a >= NREGS) return;
`ifdef HT_SLV_FRMCNT_EN
    if (a == NREGS - 1) return;
`endif
    mregs[a] = d;
  endfunction

  task automatic peek(input int a, output logic [8:0] v);
    loc_addr = 6'(a);
    #1;
    v = loc_rdata;
  endtask

  task automatic loc_write(input int a, input logic [8:0] d);
    @(negedge clk_50m);
    loc_addr = 6'(a); loc_wdata = d; loc_wr_en = 1'b1;
    @(negedge clk_50m);
    loc_wr_en = 1'b0;
    mwrite(a, d);
  endtask

  task automatic do_reset();
    @(negedge clk_50m);
    rst = 1'b1; SLOAD_pin = 1'b1; SCLK_pin = 1'b0; m_oe = 1'b0; loc_wr_en = 1'b0;
    repeat (3) @(negedge clk_50m);
    rst = 1'b0;
    for (int i = 0; i < NREGS; i++) mregs[i] = 9'h000;
    mcnt = 0;
    repeat (4) @(negedge clk_50m);
  endtask

  // One SCLK period: 5 cycles low (data set up), sample, then 5 cycles high.
  task automatic bus_bit(input logic drv, input logic v, output logic smp);
    @(negedge clk_50m);
    SCLK_pin = 1'b0; m_oe = drv; m_do = v;
    repeat (4) @(negedge clk_50m);
    @(negedge clk_50m);
    smp = SDATA_pin;
    SCLK_pin = 1'b1;
    if (coll_arm) begin
      repeat (2) @(negedge clk_50m);
      loc_addr = coll_addr; loc_wdata = coll_data; loc_wr_en = 1'b1;
      @(negedge clk_50m);
      loc_wr_en = 1'b0;
      repeat (2) @(negedge clk_50m);
    end else begin
      repeat (5) @(negedge clk_50m);
    end
  endtask

  task automatic frame_start();
    @(negedge clk_50m);
    SCLK_pin = 1'b0; SLOAD_pin = 1'b0; m_oe = 1'b0;
    repeat (5) @(negedge clk_50m);
  endtask

  task automatic frame_end(output logic rel);
    @(negedge clk_50m);
    SCLK_pin = 1'b0; m_oe = 1'b0;
    repeat (5) @(negedge clk_50m);
    rel = SDATA_pin;
    SLOAD_pin = 1'b1;
    repeat (6) @(negedge clk_50m);
  endtask

  // Full frame; abort_after < 15 raises SLOAD after that bit. Updates the model.
  task automatic send_frame(input logic [15:0] f, input int abort_after, input logic coll,
                            output logic [8:0] rd, output logic rel);
    logic s;
    logic is_rd;
    is_rd = f[0];
    rd = '0;
    frame_start();
    for (int i = 0; i < 16; i++) begin
      coll_arm = (i == 15) && coll;
      bus_bit(!(is_rd && i >= 7), f[i], s);
      coll_arm = 1'b0;
      if (i >= 7) rd[i-7] = s;
      if (i == abort_after) break;
    end
    frame_end(rel);
    if (abort_after >= 15) begin
      if (coll) mwrite(int'(coll_addr), coll_data);
      if (!is_rd) mwrite(int'(f[6:1]), f[15:7]);
      mcnt++;
    end
  endtask

  task automatic test_reset();
    logic [8:0] v;
    do_reset();
    n_cmp++; if (wr_strobe !== 1'b0) begin n_bad++; $display("FAIL reset_wr_strobe: got %b want 0", wr_strobe); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    n_cmp++; if (wr_addr !== 6'h00) begin n_bad++; $display("FAIL reset_wr_addr: got %h want 00", wr_addr); end
    n_cmp++; if (wr_data !== 9'h000) begin n_bad++; $display("FAIL reset_wr_data: got %h want 000", wr_data); end
    n_cmp++; if (SDATA_pin !== 1'b1) begin n_bad++; $display("FAIL reset_sdata_released: got %b want 1", SDATA_pin); end
    for (int a = 0; a < 64; a++) begin
      peek(a, v);
      n_cmp++; if (v !== mread(a)) begin n_bad++; $display("FAIL reset_reg[%0d]: got %h want %h", a, v, mread(a)); end
    end
  endtask

  task automatic test_write();
    logic [8:0] rd, v;
    logic rel;
    int s0;
    s0 = strobe_cnt;
    send_frame(16'h028A, 16, 1'b0, rd, rel);
    n_cmp++; if (strobe_cnt - s0 != 1) begin n_bad++; $display("FAIL write_strobe_pulses: got %0d want 1", strobe_cnt - s0); end
    n_cmp++; if (wr_addr !== 6'd5) begin n_bad++; $display("FAIL write_wr_addr: got %h want 05", wr_addr); end
    n_cmp++; if (wr_data !== 9'h005) begin n_bad++; $display("FAIL write_wr_data: got %h want 005", wr_data); end
    peek(5, v);
    n_cmp++; if (v !== 9'h005) begin n_bad++; $display("FAIL write_loc_rdata5: got %h want 005", v); end
  endtask

  task automatic test_read();
    logic [8:0] rd;
    logic rel;
    loc_write(3, 9'h1C3);
    send_frame(16'h0007, 16, 1'b0, rd, rel);
    n_cmp++; if (rd !== 9'h1C3) begin n_bad++; $display("FAIL read_bits: got %h want 1c3", rd); end
    n_cmp++; if (rel !== 1'b1) begin n_bad++; $display("FAIL read_release: got %b want 1", rel); end
  endtask

  task automatic test_abort();
    logic [8:0] rd, v, exp2;
    logic rel;
    int s0, e0;
    exp2 = mread(2);
    s0 = strobe_cnt; e0 = err_cnt;
    send_frame({9'h155, 6'd2, 1'b0}, 10, 1'b0, rd, rel);
    n_cmp++; if (err_cnt - e0 != 1) begin n_bad++; $display("FAIL abort_frame_err: got %0d want 1", err_cnt - e0); end
    n_cmp++; if (strobe_cnt != s0) begin n_bad++; $display("FAIL abort_no_strobe: got %0d want 0", strobe_cnt - s0); end
    peek(2, v);
    n_cmp++; if (v !== exp2) begin n_bad++; $display("FAIL abort_reg2: got %h want %h", v, exp2); end
    loc_write(2, 9'h0A6);
    send_frame({9'h000, 6'd2, 1'b1}, 16, 1'b0, rd, rel);
    n_cmp++; if (rd !== 9'h0A6) begin n_bad++; $display("FAIL abort_next_frame: got %h want 0a6", rd); end
  endtask

  task automatic test_out_of_range();
    logic [8:0] rd, v;
    logic rel;
    int s0;
    send_frame({9'h000, 6'd20, 1'b1}, 16, 1'b0, rd, rel);
    n_cmp++; if (rd !== 9'h000) begin n_bad++; $display("FAIL oor_read: got %h want 000", rd); end
    s0 = strobe_cnt;
    send_frame({9'h1EF, 6'd20, 1'b0}, 16, 1'b0, rd, rel);
    n_cmp++; if (strobe_cnt - s0 != 1) begin n_bad++; $display("FAIL oor_strobe: got %0d want 1", strobe_cnt - s0); end
    n_cmp++; if (wr_addr !== 6'd20) begin n_bad++; $display("FAIL oor_wr_addr: got %h want 14", wr_addr); end
    for (int a = 0; a < 32; a++) begin
      peek(a, v);
      n_cmp++; if (v !== mread(a)) begin n_bad++; $display("FAIL oor_reg[%0d]: got %h want %h", a, v, mread(a)); end
    end
  endtask

  task automatic test_collision();
    logic [8:0] rd, v;
    logic rel;
    coll_addr = 6'd7; coll_data = 9'h0F3;
    send_frame({9'h12C, 6'd7, 1'b0}, 16, 1'b1, rd, rel);
    peek(7, v);
    n_cmp++; if (v !== 9'h12C) begin n_bad++; $display("FAIL collision_serial_wins: got %h want 12c", v); end
  endtask

  task automatic test_random();
    logic [8:0] rd, v, d, ex;
    logic rel;
    int op, a, s0;
    for (int k = 0; k < 30; k++) begin
      op = int'($urandom_range(0, 2));
      a  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(16, 63)) : int'($urandom_range(0, 15));
      d  = 9'($urandom);
      case (op)
        0: begin
          loc_write(a, d);
          peek(a, v);
          n_cmp++; if (v !== mread(a)) begin n_bad++; $display("FAIL rnd_loc[%0d]: got %h want %h", a, v, mread(a)); end
        end
        1: begin
          s0 = strobe_cnt;
          send_frame({d, 6'(a), 1'b0}, 16, 1'b0, rd, rel);
          n_cmp++; if (strobe_cnt - s0 != 1) begin n_bad++; $display("FAIL rnd_wr_strobe: got %0d want 1", strobe_cnt - s0); end
          n_cmp++; if ({wr_addr, wr_data} !== {6'(a), d}) begin n_bad++; $display("FAIL rnd_wr_hold: got %h/%h want %h/%h", wr_addr, wr_data, 6'(a), d); end
          peek(a, v);
          n_cmp++; if (v !== mread(a)) begin n_bad++; $display("FAIL rnd_wr_reg[%0d]: got %h want %h", a, v, mread(a)); end
        end
        default: begin
          ex = mread(a);
          send_frame({d, 6'(a), 1'b1}, 16, 1'b0, rd, rel);
          n_cmp++; if (rd !== ex) begin n_bad++; $display("FAIL rnd_rd[%0d]: got %h want %h", a, rd, ex); end
          n_cmp++; if (rel !== 1'b1) begin n_bad++; $display("FAIL rnd_rd_release: got %b want 1", rel); end
        end
      endcase
    end
  endtask

  task automatic test_reset_midframe();
    logic [8:0] rd, v;
    logic rel, s;
    logic [15:0] f;
    loc_write(3, 9'h0F0);
    f = 16'h0007;
    frame_start();
    for (int i = 0; i < 9; i++) bus_bit(i < 7, f[i], s);
    @(negedge clk_50m);
    SCLK_pin = 1'b0; m_oe = 1'b0;
    repeat (4) @(negedge clk_50m);
    n_cmp++; if (SDATA_pin !== 1'b0) begin n_bad++; $display("FAIL midrst_driving: got %b want 0", SDATA_pin); end
    rst = 1'b1;
    #1;
    n_cmp++; if (SDATA_pin !== 1'b1) begin n_bad++; $display("FAIL midrst_release: got %b want 1", SDATA_pin); end
    SLOAD_pin = 1'b1;
    repeat (3) @(negedge clk_50m);
    rst = 1'b0;
    for (int i = 0; i < NREGS; i++) mregs[i] = 9'h000;
    mcnt = 0;
    repeat (4) @(negedge clk_50m);
    for (int a = 0; a < NREGS; a++) begin
      peek(a, v);
      n_cmp++; if (v !== mread(a)) begin n_bad++; $display("FAIL midrst_reg[%0d]: got %h want %h", a, v, mread(a)); end
    end
    send_frame({9'h19B, 6'd9, 1'b0}, 16, 1'b0, rd, rel);
    send_frame({9'h000, 6'd9, 1'b1}, 16, 1'b0, rd, rel);
    n_cmp++; if (rd !== 9'h19B) begin n_bad++; $display("FAIL midrst_next_frame: got %h want 19b", rd); end
  endtask

`ifdef HT_SLV_FRMCNT_EN
  task automatic test_frmcnt();
    logic [8:0] rd, v;
    logic rel;
    do_reset();
    send_frame({9'h011, 6'd1, 1'b0}, 16, 1'b0, rd, rel);
    send_frame({9'h000, 6'd1, 1'b1}, 16, 1'b0, rd, rel);
    send_frame({9'h022, 6'd30, 1'b0}, 16, 1'b0, rd, rel);
    send_frame({9'h033, 6'd4, 1'b0}, 9, 1'b0, rd, rel);
    send_frame({9'h000, 6'd15, 1'b1}, 16, 1'b0, rd, rel);
    n_cmp++; if (rd !== 9'h003) begin n_bad++; $display("FAIL frmcnt_read: got %h want 003", rd); end
    send_frame({9'h1FF, 6'd15, 1'b0}, 16, 1'b0, rd, rel);
    loc_write(15, 9'h0AA);
    peek(15, v);
    n_cmp++; if (v !== 9'h005) begin n_bad++; $display("FAIL frmcnt_readonly: got %h want 005", v); end
  endtask
`endif

  initial begin
    for (int i = 0; i < NREGS; i++) mregs[i] = 9'h000;
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_out_of_range();
    test_collision();
    test_random();
    test_reset_midframe();
`ifdef HT_SLV_FRMCNT_EN
    test_frmcnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
